// File: rtl/ref_block_fetcher.sv
// ref_block_fetcher: collects one reference block as 64-bit word pairs, packs each
// pair into a 15-pixel row and hands the rows to the window shift register with a
// one-cycle active-low load strobe, followed by a block-done pulse.

`default_nettype none

module ref_block_fetcher #(
    parameter int unsigned ROWS          = 15,
    parameter int unsigned WORDS_PER_ROW = 2
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [63:0]  i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [119:0] o_row_out,
    output logic         o_load_L,
    output logic [3:0]   o_row_idx,
    output logic         o_busy,
    output logic         o_block_done
);

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned WORD_W       = 64;
    localparam int unsigned PIX_PER_WORD = WORD_W / PIX_W;
    // one pixel of the second word is padding, so a row is one pixel short of two words
    localparam int unsigned ROW_PIX      = WORDS_PER_ROW * PIX_PER_WORD - 1;
    localparam int unsigned ROW_BITS     = ROW_PIX * PIX_W;
    localparam int unsigned HI_BITS      = ROW_BITS - WORD_W;
    localparam int unsigned CNT_W        = 4;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_row_cnt;
    logic [WORD_W-1:0]    r_lo;
    logic [ROW_BITS-1:0]  r_row_out;
    logic                 r_load_L;
    logic [CNT_W-1:0]     r_row_idx;
    logic                 r_busy;
    logic                 r_block_done;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_abort_act;
    logic                 w_last_row;
    logic [ROW_BITS-1:0]  w_row_next;

    // Word acceptance is a pure function of state; the transfer is the valid/ready handshake.
    assign w_in_ready  = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_xfer      = i_in_valid && w_in_ready;
    assign w_abort_act = i_abort && (r_state != ST_IDLE);
    assign w_last_row  = (r_row_cnt == LAST_ROW);

    // Row assembly: first word is pixels 0-7, low 7 pixels of the second word are 8-14.
    assign w_row_next  = {i_in_data[HI_BITS-1:0], r_lo};

    // Fetch sequencer with all registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_row_cnt    <= '0;
            r_lo         <= '0;
            r_row_out    <= '0;
            r_load_L     <= 1'b1;
            r_row_idx    <= '0;
            r_busy       <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_load_L     <= 1'b1;
            r_block_done <= 1'b0;

            if (w_abort_act) begin
                r_state   <= ST_IDLE;
                r_row_cnt <= '0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_busy) begin
                            // block_done cycle: busy drops after the pulse
                            r_busy <= 1'b0;
                        end else if (i_start && !i_abort) begin
                            r_state   <= ST_LO;
                            r_row_cnt <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_LO: begin
                        if (w_xfer) begin
                            r_lo    <= i_in_data;
                            r_state <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        if (w_xfer) begin
                            r_row_out <= w_row_next;
                            r_load_L  <= 1'b0;
                            r_row_idx <= r_row_cnt;
                            if (w_last_row) begin
                                r_row_cnt <= '0;
                                r_state   <= ST_DONE;
                            end else begin
                                r_row_cnt <= r_row_cnt + CNT_W'(1);
                                r_state   <= ST_LO;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_block_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output drive.
    assign o_in_ready   = w_in_ready;
    assign o_row_out    = r_row_out;
    assign o_load_L     = r_load_L;
    assign o_row_idx    = r_row_idx;
    assign o_busy       = r_busy;
    assign o_block_done = r_block_done;

endmodule

`default_nettype wire
